ex_mem_stage: RTL and testbench

//  EX/MEM pipeline stage directly downstream of the ID/EX latch and the ALU.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/ex_mem_stage.sv | 107 ++++++++++
 tb/tb_ex_mem_stage.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register widths, EX/MEM control bundle and
// the data-cache access state machine encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  // Field order matches the decode bundle {MemToReg,...,halt}, MSB first
  typedef struct packed {
    logic MemToReg;
    logic RegWrite;
    logic MemRead;
    logic MemWrite;
    logic Branch;
    logic BranchNE;
    logic halt;
  } mem_ctrl_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HALTED = 2'd2
  } mem_state_t;

endpackage

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: latches EX results, resolves branches, runs the
// data-cache request handshake, stalls upstream while waiting, tracks halt.
module ex_mem_stage
  import cpu_types_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WEN,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic              ex_zero,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_wsel,
  input  logic [DATA_W-1:0] ex_br_target,
  input  mem_ctrl_t         ex_ctrl,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [DATA_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  output logic              stall,
  output logic              pc_src,
  output logic [DATA_W-1:0] br_target,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_wsel,
  output logic              wb_RegWrite,
  output logic              halt_out
);

  logic              valid;
  logic [DATA_W-1:0] alu_out;
  logic              zero;
  logic [DATA_W-1:0] store_data;
  logic [REG_W-1:0]  wsel;
  logic [DATA_W-1:0] br_target_q;
  mem_ctrl_t         ctrl;
  mem_state_t        state;

  logic       capture;
  logic       in_valid;
  mem_ctrl_t  in_ctrl;
  mem_state_t enter_state;

  // Controls are zeroed for bubbles so a flushed or invalid slot never requests
  always_comb begin
    capture     = WEN && !stall;
    in_valid    = ex_valid && !flush;
    in_ctrl     = in_valid ? ex_ctrl : '0;
    enter_state = IDLE;
    if (in_ctrl.halt)
      enter_state = HALTED;
    else if (in_ctrl.MemRead || in_ctrl.MemWrite)
      enter_state = ACCESS;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid       <= 1'b0;
      alu_out     <= '0;
      zero        <= 1'b0;
      store_data  <= '0;
      wsel        <= '0;
      br_target_q <= '0;
      ctrl        <= '0;
      state       <= IDLE;
    end else begin
      if (capture) begin
        valid       <= in_valid;
        ctrl        <= in_ctrl;
        alu_out     <= ex_alu_out;
        zero        <= ex_zero;
        store_data  <= ex_store_data;
        wsel        <= ex_wsel;
        br_target_q <= ex_br_target;
      end
      case (state)
        IDLE:    if (capture) state <= enter_state;
        // On dhit the stall drops, so a new instruction may be captured on the same edge
        ACCESS:  if (dhit) state <= capture ? enter_state : IDLE;
        HALTED:  state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    dmemREN     = (state == ACCESS) && ctrl.MemRead;
    dmemWEN     = (state == ACCESS) && ctrl.MemWrite && !ctrl.MemRead;
    dmemaddr    = alu_out;
    dmemstore   = store_data;
    stall       = ((state == ACCESS) && !dhit) || (state == HALTED);
    pc_src      = valid && ctrl.Branch && (zero ^ ctrl.BranchNE);
    br_target   = br_target_q;
    wb_valid    = valid && !ctrl.halt && ((state != ACCESS) || dhit) && (state != HALTED);
    wb_data     = ctrl.MemToReg ? dmemload : alu_out;
    wb_wsel     = wsel;
    wb_RegWrite = ctrl.RegWrite && wb_valid;
    halt_out    = (state == HALTED);
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: per-feature tasks with inline checks
// plus a write-back scoreboard fed at issue time and drained on wb_valid.
module tb_ex_mem_stage;
  import cpu_types_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  wsel;
    logic        rw;
  } wb_exp_t;

  logic        CLK, RST, WEN, flush, ex_valid, ex_zero, dhit;
  logic [31:0] ex_alu_out, ex_store_data, ex_br_target, dmemload;
  logic [4:0]  ex_wsel;
  mem_ctrl_t   ex_ctrl;
  logic        dmemREN, dmemWEN, stall, pc_src, wb_valid, wb_RegWrite, halt_out;
  logic [31:0] dmemaddr, dmemstore, br_target, wb_data;
  logic [4:0]  wb_wsel;

  int checks = 0;
  int errors = 0;
  wb_exp_t sb[$];

  ex_mem_stage #(.DATA_W(32), .REG_W(5)) dut (
    .CLK(CLK), .RST(RST), .WEN(WEN), .flush(flush), .ex_valid(ex_valid),
    .ex_alu_out(ex_alu_out), .ex_zero(ex_zero), .ex_store_data(ex_store_data),
    .ex_wsel(ex_wsel), .ex_br_target(ex_br_target), .ex_ctrl(ex_ctrl),
    .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .stall(stall), .pc_src(pc_src),
    .br_target(br_target), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_wsel(wb_wsel), .wb_RegWrite(wb_RegWrite), .halt_out(halt_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scoreboard drain: every write-back must match the oldest outstanding expectation
  always @(negedge CLK) begin
    if (wb_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL wb_unexpected: got data=%h wsel=%0d with nothing outstanding", wb_data, wb_wsel);
      end else begin
        wb_exp_t e;
        e = sb.pop_front();
        if ({wb_data, wb_wsel, wb_RegWrite} !== {e.data, e.wsel, e.rw}) begin
          errors++;
          $display("[TB] FAIL wb_bundle: got data=%h wsel=%0d rw=%b expected data=%h wsel=%0d rw=%b",
                   wb_data, wb_wsel, wb_RegWrite, e.data, e.wsel, e.rw);
        end
      end
    end
  end

  function automatic mem_ctrl_t mk_ctrl(input logic mtr, rw, mr, mw, br, bne, h);
    mem_ctrl_t c;
    c = {mtr, rw, mr, mw, br, bne, h};
    return c;
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic bubble;
    WEN = 1'b1; flush = 1'b0; ex_valid = 1'b0; ex_alu_out = '0; ex_zero = 1'b0;
    ex_store_data = '0; ex_wsel = '0; ex_br_target = '0; ex_ctrl = '0;
    dhit = 1'b0; dmemload = '0;
  endtask

  task automatic set_ex(input logic [31:0] alu, input logic z, input logic [31:0] sd,
                        input logic [4:0] ws, input logic [31:0] bt, input mem_ctrl_t c);
    bubble();
    ex_valid = 1'b1; ex_alu_out = alu; ex_zero = z; ex_store_data = sd;
    ex_wsel = ws; ex_br_target = bt; ex_ctrl = c;
  endtask

  task automatic push_wb(input logic [31:0] d, input logic [4:0] ws, input logic rw);
    sb.push_back('{data: d, wsel: ws, rw: rw});
  endtask

  task automatic test_reset;
    RST = 1'b1;
    bubble();
    tick();
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if ({dmemREN, dmemWEN, stall, pc_src, wb_valid, wb_RegWrite, halt_out} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000000",
               {dmemREN, dmemWEN, stall, pc_src, wb_valid, wb_RegWrite, halt_out});
    end
    checks++;
    if ({wb_data, dmemaddr, dmemstore, br_target} !== 128'b0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h %h %h %h expected zeros", wb_data, dmemaddr, dmemstore, br_target);
    end
  endtask

  task automatic test_alu;
    tick();
    set_ex(32'h10, 1'b0, 32'h0, 5'd5, 32'h0, mk_ctrl(0, 1, 0, 0, 0, 0, 0));
    push_wb(32'h10, 5'd5, 1'b1);
    @(negedge CLK);
    tick();
    bubble();
    @(negedge CLK);
    checks++;
    if (wb_valid !== 1'b1) begin errors++; $display("[TB] FAIL alu_wb_valid: got %b expected 1", wb_valid); end
    checks++;
    if (wb_data !== 32'h10) begin errors++; $display("[TB] FAIL alu_wb_data: got %h expected 00000010", wb_data); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("[TB] FAIL alu_stall: got %b expected 0", stall); end
    tick();
    @(negedge CLK);
    checks++;
    if (wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL alu_bubble_after: got %b expected 0", wb_valid); end
  endtask

  task automatic test_load;
    tick();
    set_ex(32'h40, 1'b0, 32'h0, 5'd7, 32'h0, mk_ctrl(1, 1, 1, 0, 0, 0, 0));
    push_wb(32'hDEADBEEF, 5'd7, 1'b1);
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      tick();
      bubble();
      @(negedge CLK);
      checks++;
      if ({dmemREN, dmemWEN, stall, wb_valid} !== 4'b1010 || dmemaddr !== 32'h40) begin
        errors++;
        $display("[TB] FAIL load_wait%0d: got ren/wen/stall/wbv=%b addr=%h expected 1010 addr=00000040",
                 i, {dmemREN, dmemWEN, stall, wb_valid}, dmemaddr);
      end
    end
    tick();
    bubble();
    dhit = 1'b1; dmemload = 32'hDEADBEEF;
    @(negedge CLK);
    checks++;
    if ({stall, wb_valid} !== 2'b01 || wb_data !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL load_hit: got stall/wbv=%b data=%h expected 01 data=deadbeef", {stall, wb_valid}, wb_data);
    end
    tick();
    bubble();
    @(negedge CLK);
    checks++;
    if ({dmemREN, wb_valid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL load_done: got ren/wbv=%b expected 00", {dmemREN, wb_valid});
    end
  endtask

  task automatic test_store;
    tick();
    set_ex(32'h80, 1'b0, 32'h1234, 5'd9, 32'h0, mk_ctrl(0, 0, 0, 1, 0, 0, 0));
    push_wb(32'h80, 5'd9, 1'b0);
    @(negedge CLK);
    tick();
    bubble();
    dhit = 1'b1;
    @(negedge CLK);
    checks++;
    if ({dmemWEN, dmemREN, stall, wb_valid, wb_RegWrite} !== 5'b10010) begin
      errors++;
      $display("[TB] FAIL store_hit: got wen/ren/stall/wbv/rw=%b expected 10010", {dmemWEN, dmemREN, stall, wb_valid, wb_RegWrite});
    end
    checks++;
    if (dmemstore !== 32'h1234 || dmemaddr !== 32'h80) begin
      errors++;
      $display("[TB] FAIL store_bus: got addr=%h data=%h expected 00000080 00001234", dmemaddr, dmemstore);
    end
    tick();
    bubble();
    @(negedge CLK);
    checks++;
    if (dmemWEN !== 1'b0) begin errors++; $display("[TB] FAIL store_drop: got %b expected 0", dmemWEN); end
  endtask

  task automatic test_branch;
    tick();
    set_ex(32'h0, 1'b1, 32'h0, 5'd0, 32'h200, mk_ctrl(0, 0, 0, 0, 1, 0, 0));
    push_wb(32'h0, 5'd0, 1'b0);
    @(negedge CLK);
    tick();
    set_ex(32'h0, 1'b1, 32'h0, 5'd0, 32'h200, mk_ctrl(0, 0, 0, 0, 1, 0, 0));
    flush = 1'b1;
    @(negedge CLK);
    checks++;
    if (pc_src !== 1'b1 || br_target !== 32'h200) begin
      errors++;
      $display("[TB] FAIL beq_taken: got pc_src=%b target=%h expected 1 00000200", pc_src, br_target);
    end
    tick();
    bubble();
    @(negedge CLK);
    checks++;
    if (pc_src !== 1'b0) begin errors++; $display("[TB] FAIL beq_flushed: got %b expected 0", pc_src); end
    // BNE: zero=1 must not branch, zero=0 must
    for (int z = 1; z >= 0; z--) begin
      tick();
      set_ex(32'h0, z[0], 32'h0, 5'd0, 32'h300, mk_ctrl(0, 0, 0, 0, 1, 1, 0));
      push_wb(32'h0, 5'd0, 1'b0);
      @(negedge CLK);
      tick();
      bubble();
      @(negedge CLK);
      checks++;
      if (pc_src !== ~z[0]) begin
        errors++;
        $display("[TB] FAIL bne_zero%0d: got %b expected %b", z, pc_src, ~z[0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    tick();
    set_ex(32'h100, 1'b0, 32'h0, 5'd1, 32'h0, mk_ctrl(1, 1, 1, 0, 0, 0, 0));
    push_wb(32'hAAAA0001, 5'd1, 1'b1);
    @(negedge CLK);
    tick();
    set_ex(32'h104, 1'b0, 32'h0, 5'd2, 32'h0, mk_ctrl(1, 1, 1, 0, 0, 0, 0));
    push_wb(32'hBBBB0002, 5'd2, 1'b1);
    @(negedge CLK);
    checks++;
    if ({dmemREN, stall} !== 2'b11 || dmemaddr !== 32'h100) begin
      errors++;
      $display("[TB] FAIL b2b_first_req: got ren/stall=%b addr=%h expected 11 00000100", {dmemREN, stall}, dmemaddr);
    end
    tick();
    dhit = 1'b1; dmemload = 32'hAAAA0001;
    @(negedge CLK);
    checks++;
    if ({stall, wb_valid} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL b2b_first_hit: got stall/wbv=%b expected 01", {stall, wb_valid});
    end
    tick();
    bubble();
    @(negedge CLK);
    checks++;
    if ({dmemREN, stall, wb_valid} !== 3'b110 || dmemaddr !== 32'h104) begin
      errors++;
      $display("[TB] FAIL b2b_second_req: got ren/stall/wbv=%b addr=%h expected 110 00000104", {dmemREN, stall, wb_valid}, dmemaddr);
    end
    tick();
    bubble();
    dhit = 1'b1; dmemload = 32'hBBBB0002;
    @(negedge CLK);
    tick();
    bubble();
    @(negedge CLK);
    checks++;
    if ({dmemREN, wb_valid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL b2b_done: got ren/wbv=%b expected 00", {dmemREN, wb_valid});
    end
  endtask

  task automatic test_boundaries;
    tick();
    set_ex(32'h50, 1'b0, 32'h0, 5'd8, 32'h0, mk_ctrl(1, 1, 1, 0, 0, 0, 0));
    flush = 1'b1;
    @(negedge CLK);
    tick();
    bubble();
    dhit = 1'b1;
    @(negedge CLK);
    checks++;
    if ({dmemREN, dmemWEN, stall, wb_valid} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL flush_mem_and_idle_dhit: got %b expected 0000", {dmemREN, dmemWEN, stall, wb_valid});
    end
    tick();
    set_ex(32'h60, 1'b0, 32'h0, 5'd3, 32'h0, mk_ctrl(1, 1, 1, 0, 0, 0, 0));
    push_wb(32'h0BADF00D, 5'd3, 1'b1);
    @(negedge CLK);
    tick();
    bubble();
    WEN = 1'b0;
    @(negedge CLK);
    checks++;
    if ({dmemREN, stall} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL wen_low_keeps_req: got ren/stall=%b expected 11", {dmemREN, stall});
    end
    tick();
    bubble();
    dhit = 1'b1; dmemload = 32'h0BADF00D;
    @(negedge CLK);
    checks++;
    if (wb_valid !== 1'b1) begin errors++; $display("[TB] FAIL wen_low_hit: got %b expected 1", wb_valid); end
    tick();
    bubble();
    @(negedge CLK);
  endtask

  task automatic test_halt;
    tick();
    set_ex(32'h0, 1'b0, 32'h0, 5'd4, 32'h0, mk_ctrl(0, 1, 0, 0, 0, 0, 1));
    @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      tick();
      set_ex(32'h99, 1'b0, 32'h0, 5'd6, 32'h0, mk_ctrl(0, 1, 0, 0, 0, 0, 0));
      @(negedge CLK);
      checks++;
      if ({halt_out, stall, wb_valid, wb_RegWrite} !== 4'b1100) begin
        errors++;
        $display("[TB] FAIL halt_sticky%0d: got halt/stall/wbv/rw=%b expected 1100", i, {halt_out, stall, wb_valid, wb_RegWrite});
      end
    end
  endtask

  task automatic test_rst_mid_access;
    tick();
    bubble();
    RST = 1'b1;
    @(negedge CLK);
    tick();
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if ({halt_out, stall} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL halt_cleared: got halt/stall=%b expected 00", {halt_out, stall});
    end
    tick();
    set_ex(32'h70, 1'b0, 32'h0, 5'd6, 32'h0, mk_ctrl(1, 1, 1, 0, 0, 0, 0));
    @(negedge CLK);
    tick();
    bubble();
    @(negedge CLK);
    checks++;
    if (dmemREN !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_req: got %b expected 1", dmemREN); end
    tick();
    RST = 1'b1;
    @(negedge CLK);
    tick();
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if ({dmemREN, stall, halt_out, wb_valid} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL rst_mid_access: got ren/stall/halt/wbv=%b expected 0000", {dmemREN, stall, halt_out, wb_valid});
    end
  endtask

  initial begin
    bubble();
    RST = 1'b1;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_back_to_back();
    test_boundaries();
    test_halt();
    test_rst_mid_access();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drained: got %0d outstanding expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
